// File: rtl/arc4_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : arc4_ctrl
// Purpose  : ARC4 top-level sequencer. Fills S[i]=i, then starts ksa, then
//            starts prga over an en/rdy handshake. Owns the single S-memory
//            port and muxes the active client onto it.
// Revision : 1.0 - initial release
// ============================================================================
module arc4_ctrl #(
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic       rdy_o,
  output logic       err_o,
  output logic       ksa_en_o,
  input  logic       ksa_rdy_i,
  input  logic [7:0] ksa_addr_i,
  input  logic [7:0] ksa_wrdata_i,
  input  logic       ksa_wren_i,
  output logic [7:0] ksa_rddata_o,
  output logic       prga_en_o,
  input  logic       prga_rdy_i,
  input  logic [7:0] prga_addr_i,
  input  logic [7:0] prga_wrdata_i,
  input  logic       prga_wren_i,
  output logic [7:0] prga_rddata_o,
  output logic [7:0] s_addr_o,
  output logic [7:0] s_wrdata_o,
  output logic       s_wren_o,
  input  logic [7:0] s_rddata_i
);

  localparam int               TMO_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(BUSY_TIMEOUT);
  localparam logic [8:0]       CNT_LAST = 9'd255;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT      = 3'd1,
    S_KSA_GO    = 3'd2,
    S_KSA_BUSY  = 3'd3,
    S_KSA_RUN   = 3'd4,
    S_PRGA_GO   = 3'd5,
    S_PRGA_BUSY = 3'd6,
    S_PRGA_RUN  = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  // Registered copies of the client ready levels: the RUN states release on
  // these, so a client's ready rising hands over two cycles later.
  logic             ksa_rdy_q, prga_rdy_q;

  // State, counters, sticky error and registered client ready levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      ksa_rdy_q  <= 1'b1;
      prga_rdy_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      ksa_rdy_q  <= ksa_rdy_i;
      prga_rdy_q <= prga_rdy_i;
    end
  end

  // Next-state sequencing plus S-memory port mux selected by registered state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    s_addr_o   = 8'h00;
    s_wrdata_o = 8'h00;
    s_wren_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          cnt_d   = '0;
          state_d = S_INIT;
        end
      end

      S_INIT: begin
        s_addr_o   = cnt_q[7:0];
        s_wrdata_o = cnt_q[7:0];
        s_wren_o   = 1'b1;
        cnt_d      = cnt_q + 9'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_KSA_GO;
        end
      end

      S_KSA_GO, S_KSA_BUSY, S_KSA_RUN: begin
        s_addr_o   = ksa_addr_i;
        s_wrdata_o = ksa_wrdata_i;
        s_wren_o   = ksa_wren_i;
        if (state_q == S_KSA_GO) begin
          tmo_d   = '0;
          state_d = S_KSA_BUSY;
        end else if (state_q == S_KSA_BUSY) begin
          // A client dropping rdy on the very cycle the budget expires still counts.
          if (!ksa_rdy_i) begin
            state_d = S_KSA_RUN;
          end else if (tmo_q == TMO_MAX) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end else if (ksa_rdy_q) begin
          state_d = S_PRGA_GO;
        end
      end

      S_PRGA_GO, S_PRGA_BUSY, S_PRGA_RUN: begin
        s_addr_o   = prga_addr_i;
        s_wrdata_o = prga_wrdata_i;
        s_wren_o   = prga_wren_i;
        if (state_q == S_PRGA_GO) begin
          tmo_d   = '0;
          state_d = S_PRGA_BUSY;
        end else if (state_q == S_PRGA_BUSY) begin
          if (!prga_rdy_i) begin
            state_d = S_PRGA_RUN;
          end else if (tmo_q == TMO_MAX) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end else if (prga_rdy_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Start pulses are pure decodes of the GO states, so they can never overlap.
  assign rdy_o         = (state_q == S_IDLE);
  assign err_o         = err_q;
  assign ksa_en_o      = (state_q == S_KSA_GO);
  assign prga_en_o     = (state_q == S_PRGA_GO);
  assign ksa_rddata_o  = s_rddata_i;
  assign prga_rddata_o = s_rddata_i;

endmodule
`default_nettype wire

// File: tb/tb_arc4_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_arc4_ctrl
// Purpose  : Self-checking bench for arc4_ctrl with stub ksa/prga clients and
//            a 256x8 synchronous S-memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arc4_ctrl;

  localparam int BUSY_TIMEOUT = 8;
  localparam int KSA_RUN_LEN  = 600;
  localparam int PRGA_RUN_LEN = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy, err;
  logic       ksa_en, prga_en;
  logic       ksa_rdy, prga_rdy;
  logic [7:0] ksa_addr, ksa_wrdata, prga_addr, prga_wrdata;
  logic       ksa_wren, prga_wren;
  logic [7:0] ksa_rddata, prga_rddata;
  logic [7:0] s_addr, s_wrdata, s_rddata;
  logic       s_wren;

  int checks   = 0;
  int failures = 0;

  // Stub controls and state
  logic ksa_stuck  = 1'b0;
  logic prga_force = 1'b0;
  logic ksa_pend, prga_pend;
  int   ksa_run, prga_run;

  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  arc4_ctrl #(.BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .rdy_o        (rdy),
    .err_o        (err),
    .ksa_en_o     (ksa_en),
    .ksa_rdy_i    (ksa_rdy),
    .ksa_addr_i   (ksa_addr),
    .ksa_wrdata_i (ksa_wrdata),
    .ksa_wren_i   (ksa_wren),
    .ksa_rddata_o (ksa_rddata),
    .prga_en_o    (prga_en),
    .prga_rdy_i   (prga_rdy),
    .prga_addr_i  (prga_addr),
    .prga_wrdata_i(prga_wrdata),
    .prga_wren_i  (prga_wren),
    .prga_rddata_o(prga_rddata),
    .s_addr_o     (s_addr),
    .s_wrdata_o   (s_wrdata),
    .s_wren_o     (s_wren),
    .s_rddata_i   (s_rddata)
  );

  // S-memory model: synchronous write, one-cycle read latency
  always @(posedge clk) begin
    if (s_wren) mem[s_addr] <= s_wrdata;
    s_rddata <= mem[s_addr];
  end

  // ksa stub: rdy drops 2 cycles after en, rises KSA_RUN_LEN cycles later
  always @(posedge clk) begin
    if (!rst_n) begin
      ksa_pend <= 1'b0; ksa_rdy <= 1'b1; ksa_run <= 0;
    end else if (ksa_en && !ksa_stuck) begin
      ksa_pend <= 1'b1;
    end else if (ksa_pend) begin
      ksa_pend <= 1'b0; ksa_rdy <= 1'b0; ksa_run <= KSA_RUN_LEN;
    end else if (!ksa_rdy) begin
      ksa_run <= ksa_run - 1;
      if (ksa_run == 1) ksa_rdy <= 1'b1;
    end
  end

  // prga stub: same handshake shape with a shorter run
  always @(posedge clk) begin
    if (!rst_n) begin
      prga_pend <= 1'b0; prga_rdy <= 1'b1; prga_run <= 0;
    end else if (prga_en) begin
      prga_pend <= 1'b1;
    end else if (prga_pend) begin
      prga_pend <= 1'b0; prga_rdy <= 1'b0; prga_run <= PRGA_RUN_LEN;
    end else if (!prga_rdy) begin
      prga_run <= prga_run - 1;
      if (prga_run == 1) prga_rdy <= 1'b1;
    end
  end

  // ksa writes only 0x80-0xBF; prga writes 0xC0-0xFF unless forced onto 0x10
  assign ksa_addr    = {2'b10, ksa_run[5:0]};
  assign ksa_wrdata  = ksa_run[7:0];
  assign ksa_wren    = !ksa_rdy && ksa_run[0];
  assign prga_addr   = prga_force ? 8'h10 : {2'b11, prga_run[5:0]};
  assign prga_wrdata = prga_force ? 8'hEE : prga_run[7:0];
  assign prga_wren   = prga_force ? 1'b1  : (!prga_rdy && prga_run[0]);

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; ksa_stuck = 1'b0; prga_force = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy: got %b want 1", rdy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (ksa_en !== 1'b0 || prga_en !== 1'b0) begin failures++; $display("FAIL reset_en: ksa_en=%b prga_en=%b want 0/0", ksa_en, prga_en); end
    checks++; if (s_wren !== 1'b0 || s_addr !== 8'h00) begin failures++; $display("FAIL reset_mem: wren=%b addr=%h want 0/00", s_wren, s_addr); end
    en = 1'b1;
    @(negedge clk);
    checks++; if (rdy !== 1'b1 || s_wren !== 1'b0) begin failures++; $display("FAIL reset_en_held: rdy=%b wren=%b want 1/0", rdy, s_wren); end
    en = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_idle: rdy=%b want 1", rdy); end
  endtask

  task automatic test_init_writes();
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int go_n, go_cnt, wr_cnt, extra;
    do_reset();
    en = 1'b1;
    for (int a = 0; a < 256; a++) exp_q.push_back(8'(a));
    go_n = -1; go_cnt = 0; wr_cnt = 0; extra = 0;
    for (int n = 1; n <= 258; n++) begin
      @(negedge clk);
      en = 1'b0;
      if (n == 1) begin
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL init_rdy_low: rdy=%b want 0", rdy); end
      end
      if (s_wren === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) extra++;
        else begin
          e = exp_q.pop_front();
          checks++;
          if (s_addr !== e || s_wrdata !== e) begin
            failures++; $display("FAIL init_write: addr=%h data=%h want %h/%h", s_addr, s_wrdata, e, e);
          end
        end
      end
      if (ksa_en === 1'b1) begin go_cnt++; if (go_n < 0) go_n = n; end
    end
    checks++; if (wr_cnt != 256 || extra != 0) begin failures++; $display("FAIL init_write_count: got %0d want 256", wr_cnt); end
    checks++; if (go_cnt != 1) begin failures++; $display("FAIL ksa_en_pulses: got %0d want 1", go_cnt); end
    checks++; if (go_n != 257) begin failures++; $display("FAIL ksa_en_latency: got %0d want 257", go_n); end
  endtask

  task automatic test_full_pass();
    int rise_n, prise_n, pen_n, pen_cnt, ken_cnt, both, done_n;
    logic prev_k, prev_p;
    do_reset();
    en = 1'b1;
    rise_n = -1; prise_n = -1; pen_n = -1; pen_cnt = 0; ken_cnt = 0; both = 0; done_n = -1;
    prev_k = 1'b1; prev_p = 1'b1;
    for (int n = 1; n <= 1500 && done_n < 0; n++) begin
      @(negedge clk);
      en = 1'b0;
      if (ksa_en === 1'b1) ken_cnt++;
      if (prga_en === 1'b1) begin pen_cnt++; if (pen_n < 0) pen_n = n; end
      if (ksa_en === 1'b1 && prga_en === 1'b1) both++;
      if (ksa_rdy && !prev_k && rise_n < 0) rise_n = n;
      if (prga_rdy && !prev_p && prise_n < 0) prise_n = n;
      prev_k = ksa_rdy; prev_p = prga_rdy;
      if (n > 1 && rdy === 1'b1) done_n = n;
    end
    checks++; if (done_n < 0) begin failures++; $display("FAIL pass_timeout: rdy never returned within 1500 cycles"); end
    checks++; if (ken_cnt != 1 || pen_cnt != 1) begin failures++; $display("FAIL pass_pulses: ksa_en=%0d prga_en=%0d want 1/1", ken_cnt, pen_cnt); end
    checks++; if (both != 0) begin failures++; $display("FAIL pass_overlap: got %0d cycles want 0", both); end
    checks++; if (pen_n - rise_n != 2) begin failures++; $display("FAIL prga_en_latency: got %0d want 2", pen_n - rise_n); end
    checks++; if (done_n - prise_n != 2) begin failures++; $display("FAIL done_latency: got %0d want 2", done_n - prise_n); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL pass_err: got %b want 0", err); end
  endtask

  task automatic test_en_ignored();
    int go_n, ken_cnt, pen_cnt, klow, done_n, post_wr, post_busy;
    do_reset();
    en = 1'b1;
    go_n = -1; ken_cnt = 0; pen_cnt = 0; klow = 0; done_n = -1; post_wr = 0; post_busy = 0;
    for (int n = 1; n <= 1500 && done_n < 0; n++) begin
      @(negedge clk);
      en = 1'b0;
      if (ksa_en === 1'b1) begin ken_cnt++; if (go_n < 0) go_n = n; end
      if (prga_en === 1'b1) pen_cnt++;
      if (ksa_rdy === 1'b0) klow++;
      if (n > 1 && rdy === 1'b1) done_n = n;
      if (n == 100) en = 1'b1;
      if (klow == 10 && ksa_rdy === 1'b0) en = 1'b1;
    end
    en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (s_wren !== 1'b0) post_wr++;
      if (rdy !== 1'b1) post_busy++;
    end
    checks++; if (done_n < 0) begin failures++; $display("FAIL ign_timeout: rdy never returned within 1500 cycles"); end
    checks++; if (go_n != 257) begin failures++; $display("FAIL ign_ksa_latency: got %0d want 257", go_n); end
    checks++; if (ken_cnt != 1 || pen_cnt != 1) begin failures++; $display("FAIL ign_pulses: ksa_en=%0d prga_en=%0d want 1/1", ken_cnt, pen_cnt); end
    checks++; if (post_wr != 0 || post_busy != 0) begin failures++; $display("FAIL ign_restart: writes=%0d busy=%0d want 0/0", post_wr, post_busy); end
  endtask

  task automatic test_mux_isolation();
    int done_n;
    do_reset();
    en = 1'b1;
    done_n = -1;
    for (int n = 1; n <= 1500 && done_n < 0; n++) begin
      @(negedge clk);
      en = 1'b0;
      if (prga_force) begin
        checks++;
        if (s_wren !== ksa_wren) begin failures++; $display("FAIL mux_wren: s_wren=%b want %b", s_wren, ksa_wren); end
        if (ksa_wren === 1'b1) begin
          checks++;
          if (s_addr !== ksa_addr || s_wrdata !== ksa_wrdata) begin
            failures++; $display("FAIL mux_addr: addr=%h data=%h want %h/%h", s_addr, s_wrdata, ksa_addr, ksa_wrdata);
          end
        end
        if (ksa_rdy === 1'b1 && klow_seen(n)) begin
          prga_force = 1'b0; done_n = n;
        end
      end
      if (ksa_en === 1'b1) prga_force = 1'b1;
    end
    prga_force = 1'b0;
    checks++; if (done_n < 0) begin failures++; $display("FAIL mux_timeout: ksa run did not complete"); end
    checks++; if (mem[8'h10] !== 8'h10) begin failures++; $display("FAIL mux_mem10: got %h want 10", mem[8'h10]); end
    checks++; if (ksa_rddata !== s_rddata || prga_rddata !== s_rddata) begin failures++; $display("FAIL rddata_bcast: ksa=%h prga=%h want %h", ksa_rddata, prga_rddata, s_rddata); end
  endtask

  // True once the ksa stub has been low long enough that a high rdy means completion
  function automatic bit klow_seen(int n);
    return n > 270;
  endfunction

  task automatic test_timeout();
    int go_n, err_n, done_n, pen_cnt, ken_cnt;
    do_reset();
    ksa_stuck = 1'b1;
    en = 1'b1;
    go_n = -1; err_n = -1; done_n = -1; pen_cnt = 0;
    for (int n = 1; n <= 400 && done_n < 0; n++) begin
      @(negedge clk);
      en = 1'b0;
      if (ksa_en === 1'b1 && go_n < 0) go_n = n;
      if (err === 1'b1 && err_n < 0) err_n = n;
      if (prga_en === 1'b1) pen_cnt++;
      if (n > 1 && rdy === 1'b1) done_n = n;
    end
    ksa_stuck = 1'b0;
    checks++; if (done_n < 0) begin failures++; $display("FAIL tmo_timeout: rdy never returned within 400 cycles"); end
    checks++; if (err_n - go_n != BUSY_TIMEOUT + 2) begin failures++; $display("FAIL tmo_err_cycle: got %0d want %0d", err_n - go_n, BUSY_TIMEOUT + 2); end
    checks++; if (done_n != err_n) begin failures++; $display("FAIL tmo_rdy_cycle: got %0d want %0d", done_n, err_n); end
    checks++; if (pen_cnt != 0) begin failures++; $display("FAIL tmo_prga_en: got %0d want 0", pen_cnt); end
    // A new run with err already set proceeds normally and err stays set
    en = 1'b1;
    done_n = -1; pen_cnt = 0; ken_cnt = 0;
    for (int n = 1; n <= 1500 && done_n < 0; n++) begin
      @(negedge clk);
      en = 1'b0;
      if (ksa_en === 1'b1) ken_cnt++;
      if (prga_en === 1'b1) pen_cnt++;
      if (n > 1 && rdy === 1'b1) done_n = n;
    end
    checks++; if (done_n < 0 || ken_cnt != 1 || pen_cnt != 1) begin failures++; $display("FAIL err_rerun: done=%0d ksa_en=%0d prga_en=%0d want >0/1/1", done_n, ken_cnt, pen_cnt); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int klow, wr_cnt;
    en = 1'b1;
    klow = 0;
    for (int n = 1; n <= 1000 && klow < 50; n++) begin
      @(negedge clk);
      en = 1'b0;
      if (ksa_rdy === 1'b0) klow++;
    end
    checks++; if (klow < 50) begin failures++; $display("FAIL midrst_reach: ksa low cycles=%0d want 50", klow); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (rdy !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL midrst_state: rdy=%b err=%b want 1/0", rdy, err); end
    checks++; if (s_wren !== 1'b0 || ksa_en !== 1'b0 || prga_en !== 1'b0) begin failures++; $display("FAIL midrst_outs: wren=%b ksa_en=%b prga_en=%b want 0/0/0", s_wren, ksa_en, prga_en); end
    en = 1'b1;
    for (int a = 0; a < 4; a++) exp_q.push_back(8'(a));
    wr_cnt = 0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      en = 1'b0;
      if (s_wren === 1'b1 && exp_q.size() != 0) begin
        wr_cnt++;
        e = exp_q.pop_front();
        checks++;
        if (s_addr !== e || s_wrdata !== e) begin failures++; $display("FAIL midrst_restart: addr=%h data=%h want %h/%h", s_addr, s_wrdata, e, e); end
      end
    end
    checks++; if (wr_cnt != 4) begin failures++; $display("FAIL midrst_writes: got %0d want 4", wr_cnt); end
    do_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    test_reset();
    test_init_writes();
    test_full_pass();
    test_en_ignored();
    test_mux_isolation();
    test_timeout();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
